// File: rtl/park_pkg.sv
// Shared definitions for the park gate controller and the occupancy counter.
package park_pkg;

   // Occupancy counter width and default capacity, shared with the counter.
   localparam int unsigned               PARK_CNT_W    = 4;
   localparam logic [PARK_CNT_W-1:0]     PARK_CAPACITY = 4'd12;

   // Direction FSM state encoding.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EN_A  = 3'd1,
      ST_EN_AB = 3'd2,
      ST_EN_B  = 3'd3,
      ST_EX_B  = 3'd4,
      ST_EX_BA = 3'd5,
      ST_EX_A  = 3'd6
   } gate_state_e;

   // Debounced beam pair, a = street side, b = lot side.
   typedef struct packed {
      logic a;
      logic b;
   } beam_pair_t;

endpackage

// File: rtl/sensor_debounce.sv
// 2-flop synchroniser followed by a level debouncer for one raw beam sensor.
// Ports: clk, rst (async active-low), raw_in (asynchronous raw level),
//        db_out (debounced level, changes after DEB_CYCLES differing samples).
module sensor_debounce #(
   parameter int unsigned DEB_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic db_out
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

   logic          sync1_q, sync2_q;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchroniser and debounce state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   // Accept the new level on the DEB_CYCLES-th consecutive differing sample.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            db_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign db_out = db_q;

endmodule

// File: rtl/park_gate_ctrl.sv
// Park gate entry/exit detector: debounces the street (A) and lot (B) beams,
// tracks the car direction and pulses the occupancy counter.
// Ports: clk, rst (async active-low), sensor_a/sensor_b (raw beams, 1=blocked),
//        count (occupancy), count_up/count_down/err (1-cycle pulses),
//        full, gate_open, denied (registered levels).
module park_gate_ctrl
   import park_pkg::*;
#(
   parameter int unsigned            CNT_W          = PARK_CNT_W,
   parameter logic [CNT_W-1:0]       CAPACITY       = PARK_CAPACITY,
   parameter int unsigned            DEB_CYCLES     = 8,
   parameter int unsigned            TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sensor_a,
   input  logic             sensor_b,
   input  logic [CNT_W-1:0] count,
   output logic             count_up,
   output logic             count_down,
   output logic             full,
   output logic             gate_open,
   output logic             denied,
   output logic             err
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   beam_pair_t  beams;
   gate_state_e state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic up_q, up_d, down_q, down_d, err_q, err_d;
   logic full_q, denied_q, denied_d, gate_q;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
      .clk    (clk),
      .rst    (rst),
      .raw_in (sensor_a),
      .db_out (beams.a)
   );

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clk    (clk),
      .rst    (rst),
      .raw_in (sensor_b),
      .db_out (beams.b)
   );

   // State, timeout counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         tmo_q    <= '0;
         up_q     <= 1'b0;
         down_q   <= 1'b0;
         err_q    <= 1'b0;
         full_q   <= 1'b0;
         denied_q <= 1'b0;
         gate_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         up_q     <= up_d;
         down_q   <= down_d;
         err_q    <= err_d;
         full_q   <= (count >= CAPACITY);
         denied_q <= denied_d;
         gate_q   <= (state_q != ST_IDLE);
      end
   end

   // Direction FSM; timeout abort takes priority over any beam transition.
   always_comb begin
      state_d  = state_q;
      up_d     = 1'b0;
      down_d   = 1'b0;
      err_d    = 1'b0;
      denied_d = 1'b0;
      tmo_d    = '0;

      if ((state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (beams == 2'b10 && !full_q) state_d = ST_EN_A;
               else if (beams == 2'b01)       state_d = ST_EX_B;
            end
            ST_EN_A: begin
               if (beams == 2'b11)      state_d = ST_EN_AB;
               else if (beams == 2'b00) state_d = ST_IDLE;
            end
            ST_EN_AB: begin
               if (beams == 2'b01)      state_d = ST_EN_B;
               else if (beams == 2'b10) state_d = ST_EN_A;
               else if (beams == 2'b00) state_d = ST_IDLE;
            end
            ST_EN_B: begin
               if (beams == 2'b00) begin
                  state_d = ST_IDLE;
                  up_d    = 1'b1;
               end else if (beams == 2'b11) state_d = ST_EN_AB;
               else if (beams == 2'b10)     state_d = ST_IDLE;
            end
            ST_EX_B: begin
               if (beams == 2'b11)      state_d = ST_EX_BA;
               else if (beams == 2'b00) state_d = ST_IDLE;
            end
            ST_EX_BA: begin
               if (beams == 2'b10)      state_d = ST_EX_A;
               else if (beams == 2'b01) state_d = ST_EX_B;
               else if (beams == 2'b00) state_d = ST_IDLE;
            end
            ST_EX_A: begin
               if (beams == 2'b00) begin
                  state_d = ST_IDLE;
                  down_d  = 1'b1;
               end else if (beams == 2'b11) state_d = ST_EX_BA;
               else if (beams == 2'b01)     state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Dwell counter: runs only while a passage is in progress in one state.
      if ((state_q != ST_IDLE) && (state_d == state_q)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      denied_d = (state_q == ST_IDLE) && (beams == 2'b10) && full_q;
   end

   assign count_up   = up_q;
   assign count_down = down_q;
   assign err        = err_q;
   assign full       = full_q;
   assign denied     = denied_q;
   assign gate_open  = gate_q;

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Scoreboard bench for park_gate_ctrl: expected pulses (kind + cycle) are queued
// when the stimulus is driven and matched against DUT pulses as they appear.
module tb_park_gate_ctrl;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned DEB     = 4;
   localparam int unsigned TMO     = 64;
   localparam int          LAT     = DEB + 3;   // raw drive to pulse, in cycles
   localparam int          K_UP    = 1;
   localparam int          K_DOWN  = 2;
   localparam int          K_ERR   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sensor_a = 1'b0;
   logic             sensor_b = 1'b0;
   logic [CNT_W-1:0] count = '0;
   logic             count_up, count_down, full, gate_open, denied, err;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc      = 0;
   int   n_cmp    = 0;
   int   n_err    = 0;
   bit   saw_gate = 1'b0;

   park_gate_ctrl #(
      .CNT_W          (CNT_W),
      .CAPACITY       (4'd12),
      .DEB_CYCLES     (DEB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sensor_a   (sensor_a),
      .sensor_b   (sensor_b),
      .count      (count),
      .count_up   (count_up),
      .count_down (count_down),
      .full       (full),
      .gate_open  (gate_open),
      .denied     (denied),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Pulse monitor: every DUT pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         int   code;
         exp_t e;
         code = int'({err, count_down, count_up});
         check_eq("up_down_exclusive", int'(count_up & count_down), 0);
         if (code != 0) begin
            if (sb_q.size() == 0) begin
               check_eq("spurious_pulse", code, 0);
            end else begin
               e = sb_q.pop_front();
               check_eq("pulse_kind", code, e.kind);
               check_eq("pulse_cycle", cyc, e.cyc);
            end
         end
         if (gate_open) saw_gate = 1'b1;
      end
   end

   // Drive a raw beam pair at a negedge, optionally queue the pulse it should cause.
   task automatic drive(input logic a, input logic b, input int hold, input int exp_kind);
      sensor_a = a;
      sensor_b = b;
      if (exp_kind == K_UP || exp_kind == K_DOWN) sb_q.push_back('{exp_kind, cyc + LAT});
      else if (exp_kind == K_ERR)                 sb_q.push_back('{K_ERR, cyc + LAT + int'(TMO)});
      repeat (hold) @(negedge clk);
   endtask

   task automatic outs_zero(input string tag);
      check_eq(tag, int'({count_up, count_down, full, gate_open, denied, err}), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      outs_zero("reset_outputs");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      outs_zero("post_reset_idle");

      // Clean entry.
      count = 4'd3;
      drive(1'b1, 1'b0, 10, 0);
      drive(1'b1, 1'b1, 10, 0);
      drive(1'b0, 1'b1, 10, 0);
      check_eq("entry_gate_open", int'(gate_open), 1);
      drive(1'b0, 1'b0, 20, K_UP);
      check_eq("entry_gate_closed", int'(gate_open), 0);
      check_eq("entry_sb_drained", sb_q.size(), 0);

      // Clean exit.
      count = 4'd5;
      drive(1'b0, 1'b1, 10, 0);
      drive(1'b1, 1'b1, 10, 0);
      check_eq("exit_gate_open", int'(gate_open), 1);
      drive(1'b1, 1'b0, 10, 0);
      drive(1'b0, 1'b0, 20, K_DOWN);
      check_eq("exit_gate_closed", int'(gate_open), 0);
      check_eq("exit_sb_drained", sb_q.size(), 0);

      // Bouncing A never settles long enough to be accepted.
      saw_gate = 1'b0;
      for (int i = 0; i < 10; i++) drive(~sensor_a, 1'b0, 2, 0);
      drive(1'b0, 1'b0, 10, 0);
      check_eq("bounce_no_gate", int'(saw_gate), 0);

      // Car backs out after reaching both beams.
      drive(1'b1, 1'b0, 10, 0);
      drive(1'b1, 1'b1, 10, 0);
      drive(1'b1, 1'b0, 10, 0);
      drive(1'b0, 1'b0, 15, 0);
      check_eq("backout_idle_gate", int'(gate_open), 0);
      check_eq("backout_sb_drained", sb_q.size(), 0);

      // full threshold is inclusive and unsigned.
      count = 4'd15;
      repeat (2) @(negedge clk);
      check_eq("full_at_15", int'(full), 1);
      count = 4'd11;
      repeat (2) @(negedge clk);
      check_eq("full_at_11", int'(full), 0);

      // Full park: A blocked is denied until a space frees up.
      count = 4'd12;
      drive(1'b1, 1'b0, 20, 0);
      check_eq("full_flag", int'(full), 1);
      check_eq("full_denied", int'(denied), 1);
      check_eq("full_gate_shut", int'(gate_open), 0);
      count = 4'd11;
      repeat (3) @(negedge clk);
      check_eq("unfull_denied", int'(denied), 0);
      check_eq("unfull_gate_open", int'(gate_open), 1);
      drive(1'b0, 1'b0, 15, 0);
      check_eq("unfull_abort_gate", int'(gate_open), 0);

      // Timeout while parked in EN_AB.
      count = 4'd3;
      drive(1'b1, 1'b0, 10, 0);
      drive(1'b1, 1'b1, 100, K_ERR);
      check_eq("timeout_gate_closed", int'(gate_open), 0);
      drive(1'b0, 1'b0, 15, 0);
      check_eq("timeout_sb_drained", sb_q.size(), 0);

      // Asynchronous reset while in EN_B.
      drive(1'b1, 1'b0, 10, 0);
      drive(1'b1, 1'b1, 10, 0);
      drive(1'b0, 1'b1, 10, 0);
      check_eq("enb_gate_open", int'(gate_open), 1);
      #3 rst = 1'b0;
      #1 outs_zero("async_reset_outputs");
      sensor_b = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      repeat (30) @(negedge clk);
      check_eq("post_reset_gate", int'(gate_open), 0);
      check_eq("final_sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/park_gate_ctrl.md
Name: park_gate_ctrl

Overview:
- Entry/exit detector for one park gate, directly upstream of the occupancy counter.
- Reads two raw beam sensors: A on the street side, B on the lot side. It synchronises and debounces them, then tracks the car's passage with a direction FSM.
- Emits single-cycle count_up / count_down pulses that drive the counter's inputs. Reads back the counter's count to block entry when the park is full.

Parameters:
- CNT_W, 4, width of count; matches the counter output.
- CAPACITY, 4'd12, number of spaces; full when count >= CAPACITY.
- DEB_CYCLES, 8, consecutive equal synchronised samples required to accept a sensor level change (>=1).
- TIMEOUT_CYCLES, 1000000, maximum cycles allowed in any non-IDLE state before abort.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-low reset (0 = reset).
- sensor_a, input, 1, raw street-side beam, 1 = blocked; asynchronous to clk.
- sensor_b, input, 1, raw lot-side beam, 1 = blocked; asynchronous to clk.
- count, input, CNT_W, current occupancy from the counter.
- count_up, output, 1, one-cycle pulse on a completed entry.
- count_down, output, 1, one-cycle pulse on a completed exit.
- full, output, 1, registered; count >= CAPACITY.
- gate_open, output, 1, barrier open command.
- denied, output, 1, high while a car waits at A and full=1.
- err, output, 1, one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst=0, async): all of the following take their reset value.
  - FSM = IDLE.
  - Synchroniser flops = 0, debounced a/b = 0, debounce counters = 0, timeout counter = 0.
  - All outputs = 0.
- Input path, per sensor:
  - 2-flop synchroniser, then debounce.
  - Debounce: the debounced value changes only after DEB_CYCLES consecutive synchronised samples differ from it. Any sample equal to the current debounced value clears the debounce counter.
  - Worst latency from a raw edge to a debounced edge = 2 + DEB_CYCLES cycles.
- full: registered each cycle from (count >= CAPACITY), unsigned compare. Reflects count one cycle later.
- FSM is evaluated on debounced {a,b}. States and transitions (any pair not listed = stay in current state):
  - IDLE:
    - 10 -> EN_A if full=0.
    - 10 with full=1 -> stay IDLE and assert denied.
    - 01 -> EX_B.
    - 11 and 00 -> stay.
  - EN_A: 11 -> EN_AB; 00 -> IDLE (abort, no pulse).
  - EN_AB: 01 -> EN_B; 10 -> EN_A; 00 -> IDLE.
  - EN_B: 00 -> IDLE with count_up=1 next cycle; 11 -> EN_AB; 10 -> IDLE (abort).
  - EX_B: 11 -> EX_BA; 00 -> IDLE.
  - EX_BA: 10 -> EX_A; 01 -> EX_B; 00 -> IDLE.
  - EX_A: 00 -> IDLE with count_down=1 next cycle; 11 -> EX_BA; 01 -> IDLE (abort).
- Pulses:
  - count_up and count_down are registered and high for exactly one cycle.
  - They are never high simultaneously.
  - count_down is issued even when count=0; the counter guards underflow.
- full changing mid-entry does not abort an entry already in progress. full is sampled only at IDLE.
- gate_open = 1 in every EN_* and EX_* state, registered (one cycle after the state is entered). 0 in IDLE.
- denied: registered; 1 in any cycle where state=IDLE, debounced {a,b}=10 and full=1, else 0.
- Timeout:
  - The counter runs in non-IDLE states and clears on every state change.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse err for 1 cycle, no count pulse.
- Reset asserted mid-passage: immediate return to IDLE, no pulse emitted. After release, a car still in the beams is seen from IDLE. 11 is ignored; 10/01 starts a new passage.
- Simultaneous debounced change of both sensors is allowed; treated as the resulting pair per the transitions above.

Decomposition:
- Shared package park_pkg holds:
  - FSM state encoding constants (IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A; 3 bits).
  - CNT_W and default CAPACITY, so the counter and this block agree.
- One sub-module, sensor_debounce (params DEB_CYCLES; ports clk, rst, raw_in, db_out), holds the synchroniser plus debounce counter. Instantiated twice.
- FSM, timeout, full/denied and pulse logic live in park_gate_ctrl.

Test Plan (sim params DEB_CYCLES=4, TIMEOUT_CYCLES=64, CAPACITY=12):
- Clean entry, count=3: raw AB = 10, 11, 01, 00, each held 10 cycles.
  - count_up is high for exactly 1 cycle, 1 cycle after debounced 00.
  - gate_open is 1 during the passage and 0 after.
  - count_down stays 0.
- Clean exit, count=5: AB = 01, 11, 10, 00.
  - Exactly one count_down pulse; no count_up.
- Bounce and reversal:
  - sensor_a toggles every 2 cycles for 20 cycles, then returns to 0: no state change, no pulses.
  - Separately, AB = 10, 11, 10, 00 (car backs out): no pulses, ends in IDLE.
- Full park, count=12: AB = 10 held 20 cycles.
  - full=1, denied=1, gate_open=0, state IDLE, no count_up.
  - Then drop count to 11 with A still blocked: EN_A entered, denied=0.
- Timeout: AB = 10, 11, then held 100 cycles.
  - err pulses once 64 cycles after entering EN_AB.
  - State returns to IDLE; no count_up.
- Reset mid-passage: in EN_B, drive rst=0 for 3 cycles asynchronously (not clock-aligned).
  - All outputs are 0 immediately.
  - After release with AB=00, no count_up is ever emitted.
